aes_round_ctrl: RTL
===================

# aes_round_ctrl

Round sequencer for the iterative AES datapath. Accepts a start request with a key-size mode, derives the round count (10/12/14), and steps the datapath through key load, middle rounds and final round one round per cycle. Presents the finished block with a valid/ack handshake. Sits between the top-level control/demo logic and the AES round datapath, replacing free-running combinational `nr`/counter selection with a registered, handshaked schedule.

## Interface
Parameters:
- None. Widths and constants come from the shared package.

Ports:
- `clk`  in  1  — single clock; all state is updated on the rising edge.
- `reset`  in  1  — asynchronous, active-high; clears all state.
- `start`  in  1  — request to run one block; sampled only in IDLE.
- `mode`  in  2  — key size, sampled with `start`: 1 = AES-128, 2 = AES-192, 3 = AES-256, 0 = invalid.
- `hold`  in  1  — datapath stall; freezes the sequence while high.
- `out_ack`  in  1  — consumer accepts the result.
- `busy`  out  1  — high in every state except IDLE.
- `nr`  out  4  — latched round count: 10, 12 or 14.
- `round`  out  4  — current round index, 0..nr.
- `key_load`  out  1  — load input block and key; apply round-0 AddRoundKey.
- `round_en`  out  1  — datapath executes round `round` this cycle.
- `final_round`  out  1  — current round omits MixColumns.
- `out_valid`  out  1  — result available; held until acknowledged.
- `err`  out  1  — one-cycle pulse when `start` arrives with `mode` = 0.

## Operation
- States:
  - IDLE
  - LOAD
  - ROUND
  - FINAL
  - DONE
- IDLE:
  - On `start` with a valid `mode`: latch `nr` (1→10, 2→12, 3→14), set `round` = 0, go to LOAD.
  - On `start` with `mode` = 0: pulse `err` on the next cycle and stay in IDLE.
- LOAD:
  - `key_load` = 1, `round` = 0.
  - If `hold` = 0: go to ROUND with `round` = 1.
- ROUND:
  - `round_en` = 1 when `hold` = 0.
  - `round` increments on each non-held cycle.
  - When `round` = nr−1 and the cycle is not held: go to FINAL with `round` = nr.
- FINAL:
  - `round_en` = 1 and `final_round` = 1 when `hold` = 0.
  - If `hold` = 0: go to DONE.
- DONE:
  - `out_valid` = 1 and `round` keeps the value nr.
  - On `out_ack`: go to IDLE. `out_valid` drops on the next cycle.
- `hold` behaviour:
  - While high, state and `round` are frozen.
  - `key_load`, `round_en` and `final_round` are forced to 0.
  - `hold` has no effect in IDLE or DONE.
- `start` outside IDLE is ignored, including in the ack cycle; no queuing.
- Changes on `mode` outside the start-accept cycle are ignored.
- Strobes (`key_load`, `round_en`, `final_round`) are combinational decodes of state and `hold`. `out_valid`, `busy` and `err` are decodes of the registered state or registered flags.
- `round` never exceeds `nr` and never wraps.

## Timing
- Reset values:
  - State IDLE, `round` = 0, `nr` = 0.
  - All other outputs 0.
- Reset asserted mid-operation aborts immediately to IDLE. No `out_valid` or `err` is produced for the aborted block.
- With no `hold`, counting start at edge 0:
  - LOAD occupies cycle 1.
  - ROUND occupies cycles 2..nr.
  - FINAL occupies cycle nr+1.
  - `out_valid` rises at cycle nr+2: 12 cycles for AES-128, 14 for AES-192, 16 for AES-256.
- Each held cycle adds exactly one cycle of latency.
- If `out_ack` arrives in the first DONE cycle, `busy` and `out_valid` are low the next cycle. A new `start` is accepted one cycle after that (IDLE).
- `err` is high for exactly one cycle, the cycle after the offending `start`.

## Structure
- Shared package `aes_pkg` holds:
  - Mode constants: `MODE_128` = 1, `MODE_192` = 2, `MODE_256` = 3.
  - Round-count constants: `NR_128` = 10, `NR_192` = 12, `NR_256` = 14.
  - The state encoding.
- One small sub-module, `aes_nr_decode`: combinational mode→nr map plus an invalid flag. It is shared with the key-expansion block.
- The FSM and round counter live in `aes_round_ctrl`.

## Test plan
- AES-128, no hold: `start` with `mode` = 1:
  - `nr` = 10.
  - `key_load` on cycle 1.
  - `round_en` on rounds 1–10, with `final_round` only at `round` = 10.
  - `out_valid` at cycle 12.
  - `out_ack` → IDLE.
- AES-192 and AES-256 back-to-back:
  - `out_valid` at cycles 14 and 16 respectively.
  - The second `start` is issued during `busy` and must be ignored.
  - The second block is accepted only after IDLE is reached.
- `hold` high for 3 cycles during `round` = 5 of AES-128:
  - `round` frozen at 5 and `round_en` = 0 for those cycles.
  - `out_valid` at cycle 15.
- `start` with `mode` = 0 → single-cycle `err`, `busy` stays 0, no strobes.
- Reset asserted in ROUND at `round` = 7 of AES-256:
  - All outputs 0 immediately.
  - A subsequent `start` runs a clean 16-cycle sequence.
- `out_valid` held for 5 cycles without `out_ack`:
  - `round` = nr stable, no strobes.
  - `mode` toggling has no effect.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants and round-sequencer state encoding
package aes_pkg;

    localparam int MODE_W = 2;
    localparam int NR_W   = 4;

    localparam logic [MODE_W-1:0] MODE_128 = 2'd1;
    localparam logic [MODE_W-1:0] MODE_192 = 2'd2;
    localparam logic [MODE_W-1:0] MODE_256 = 2'd3;

    localparam logic [NR_W-1:0] NR_128 = 4'd10;
    localparam logic [NR_W-1:0] NR_192 = 4'd12;
    localparam logic [NR_W-1:0] NR_256 = 4'd14;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } aes_state_e;

endpackage

// File: rtl/aes_nr_decode.sv
// rtl/aes_nr_decode.sv - key-size mode to round-count map with invalid flag
module aes_nr_decode
    import aes_pkg::*;
(
    input  logic [MODE_W-1:0] mode,
    output logic [NR_W-1:0]   nr,
    output logic              invalid
);

    always_comb begin
        nr      = '0;
        invalid = 1'b0;
        case (mode)
            MODE_128: nr = NR_128;
            MODE_192: nr = NR_192;
            MODE_256: nr = NR_256;
            default:  invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - handshaked round schedule for the iterative AES datapath
module aes_round_ctrl
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [MODE_W-1:0] mode,
    input  logic              hold,
    input  logic              out_ack,
    output logic              busy,
    output logic [NR_W-1:0]   nr,
    output logic [NR_W-1:0]   round,
    output logic              key_load,
    output logic              round_en,
    output logic              final_round,
    output logic              out_valid,
    output logic              err
);

    aes_state_e      state_q, state_d;
    logic [NR_W-1:0] round_q, round_d;
    logic [NR_W-1:0] nr_q, nr_d;
    logic            err_q, err_d;
    logic [NR_W-1:0] dec_nr;
    logic            dec_invalid;

    aes_nr_decode u_nr_decode (
        .mode    (mode),
        .nr      (dec_nr),
        .invalid (dec_invalid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            nr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            nr_q    <= nr_d;
            err_q   <= err_d;
        end
    end

    // Strobes decode directly from state and hold so a stall masks them in the same cycle.
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        nr_d        = nr_q;
        err_d       = 1'b0;
        key_load    = 1'b0;
        round_en    = 1'b0;
        final_round = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (dec_invalid) begin
                        err_d = 1'b1;
                    end else begin
                        nr_d    = dec_nr;
                        round_d = '0;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (!hold) begin
                    key_load = 1'b1;
                    round_d  = 4'd1;
                    state_d  = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (!hold) begin
                    round_en = 1'b1;
                    round_d  = round_q + 4'd1;
                    if (round_q == nr_q - 4'd1) begin
                        state_d = ST_FINAL;
                    end
                end
            end
            ST_FINAL: begin
                if (!hold) begin
                    round_en    = 1'b1;
                    final_round = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ack) begin
                    round_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign err       = err_q;
    assign nr        = nr_q;
    assign round     = round_q;

endmodule
